// File: rtl/div_seq_serializer.sv
// Parallel-to-serial feeder for the div-by-N serial checkers: clears the checker,
// streams a word MSB-first, then strobes when the checker's verdict is valid.
module div_seq_serializer #(
    parameter int W          = 8,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             chk_rst,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             res_strobe,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int BCW = $clog2(W) + 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);
    localparam logic [3:0]     LAST_GAP = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, GAP} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   shift_reg, shift_nxt;
    logic [BCW-1:0] bit_cnt, bit_cnt_nxt;
    logic [3:0]     gap_cnt, gap_cnt_nxt;
    logic           accept;
    logic           chk_rst_nxt, ser_bit_nxt, ser_valid_nxt, ser_first_nxt, ser_last_nxt;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CLR;
            CLR:     state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == LAST_GAP) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Serial outputs are registered, so they are derived from the next-cycle
    // state and shift register rather than the current ones.
    always_comb begin
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        case (state)
            IDLE:  if (accept) shift_nxt = in_data;
            CLR:   bit_cnt_nxt = '0;
            SHIFT: begin
                shift_nxt   = {shift_reg[W-2:0], 1'b0};
                bit_cnt_nxt = bit_cnt + BCW'(1);
                gap_cnt_nxt = '0;
            end
            GAP:   gap_cnt_nxt = gap_cnt + 4'd1;
            default: ;
        endcase
        chk_rst_nxt   = (state_nxt == CLR);
        ser_valid_nxt = (state_nxt == SHIFT);
        ser_bit_nxt   = ser_valid_nxt && shift_nxt[W-1];
        ser_first_nxt = ser_valid_nxt && (bit_cnt_nxt == '0);
        ser_last_nxt  = ser_valid_nxt && (bit_cnt_nxt == LAST_BIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            chk_rst    <= 1'b0;
            ser_bit    <= 1'b0;
            ser_valid  <= 1'b0;
            ser_first  <= 1'b0;
            ser_last   <= 1'b0;
            res_strobe <= 1'b0;
            word_cnt   <= '0;
        end else begin
            shift_reg  <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            chk_rst    <= chk_rst_nxt;
            ser_bit    <= ser_bit_nxt;
            ser_valid  <= ser_valid_nxt;
            ser_first  <= ser_first_nxt;
            ser_last   <= ser_last_nxt;
            res_strobe <= ser_valid && ser_last;
            if (ser_valid && ser_last) word_cnt <= word_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_div_seq_serializer.sv
// Directed bench for div_seq_serializer: default, zero-gap and narrow-counter
// instances, plus a behavioural div-by-9 checker fed from the default instance.
module tb_div_seq_serializer;

    logic clk;
    int   checks = 0;
    int   passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: W=8, GAP_CYCLES=1, CNT_W=16
    logic        a_rst, a_valid, a_in_ready, a_chk_rst, a_ser_bit, a_ser_valid;
    logic        a_ser_first, a_ser_last, a_res_strobe;
    logic [7:0]  a_data;
    logic [15:0] a_word_cnt;
    logic [6:0]  a_flags;
    assign a_flags = {a_chk_rst, a_ser_valid, a_ser_bit, a_ser_first, a_ser_last, a_res_strobe, a_in_ready};

    div_seq_serializer #(.W(8), .GAP_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_in_ready),
        .chk_rst(a_chk_rst), .ser_bit(a_ser_bit), .ser_valid(a_ser_valid), .ser_first(a_ser_first),
        .ser_last(a_ser_last), .res_strobe(a_res_strobe), .word_cnt(a_word_cnt));

    // Instance B: W=8, GAP_CYCLES=0
    logic        b_rst, b_valid, b_in_ready, b_chk_rst, b_ser_bit, b_ser_valid;
    logic        b_ser_first, b_ser_last, b_res_strobe;
    logic [7:0]  b_data;
    logic [15:0] b_word_cnt;
    logic [6:0]  b_flags;
    assign b_flags = {b_chk_rst, b_ser_valid, b_ser_bit, b_ser_first, b_ser_last, b_res_strobe, b_in_ready};

    div_seq_serializer #(.W(8), .GAP_CYCLES(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_in_ready),
        .chk_rst(b_chk_rst), .ser_bit(b_ser_bit), .ser_valid(b_ser_valid), .ser_first(b_ser_first),
        .ser_last(b_ser_last), .res_strobe(b_res_strobe), .word_cnt(b_word_cnt));

    // Instance C: W=4, GAP_CYCLES=1, CNT_W=2
    logic        c_rst, c_valid, c_in_ready, c_chk_rst, c_ser_bit, c_ser_valid;
    logic        c_ser_first, c_ser_last, c_res_strobe;
    logic [3:0]  c_data;
    logic [1:0]  c_word_cnt;

    div_seq_serializer #(.W(4), .GAP_CYCLES(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(c_rst), .in_valid(c_valid), .in_data(c_data), .in_ready(c_in_ready),
        .chk_rst(c_chk_rst), .ser_bit(c_ser_bit), .ser_valid(c_ser_valid), .ser_first(c_ser_first),
        .ser_last(c_ser_last), .res_strobe(c_res_strobe), .word_cnt(c_word_cnt));

    // Behavioural div-by-9 checker: remainder register, verdict = (rem == 0)
    logic [3:0] rem9;
    logic       chk_out;
    always_ff @(posedge clk) begin
        if (a_chk_rst)        rem9 <= 4'd0;
        else if (a_ser_valid) rem9 <= 4'((32'(rem9) * 2 + 32'(a_ser_bit)) % 9);
    end
    assign chk_out = (rem9 == 4'd0);

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic reset_a;
        a_rst = 1'b1; a_valid = 1'b0;
        step;
        a_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        a_rst = 1'b1; a_valid = 1'b0; a_data = 8'h00;
        step; step;
        checks++; if (a_flags !== 7'b0000000) $display("FAIL reset_flags got %b want %b", a_flags, 7'b0000000); else passes++;
        checks++; if (a_word_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", a_word_cnt); else passes++;
        a_rst = 1'b0;
        #1;
        checks++; if (a_flags !== 7'b0000001) $display("FAIL reset_idle got %b want %b", a_flags, 7'b0000001); else passes++;
    endtask

    task automatic test_single;
        logic [7:0] w;
        logic [6:0] e;
        w = 8'h12;
        a_valid = 1'b1; a_data = w;
        #1;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL single_ready got %b want 1", a_in_ready); else passes++;
        step;
        a_valid = 1'b0; a_data = 8'hFF;
        #1;
        checks++; if (a_flags !== 7'b1000000) $display("FAIL single_clr got %b want %b", a_flags, 7'b1000000); else passes++;
        for (int i = 0; i < 8; i++) begin
            step;
            e = {1'b0, 1'b1, w[7-i], (i == 0), (i == 7), 1'b0, 1'b0};
            checks++; if (a_flags !== e) $display("FAIL single_bit%0d got %b want %b", i, a_flags, e); else passes++;
        end
        step;
        checks++; if (a_flags !== 7'b0000010) $display("FAIL single_strobe got %b want %b", a_flags, 7'b0000010); else passes++;
        checks++; if (a_word_cnt !== 16'd1) $display("FAIL single_cnt got %0d want 1", a_word_cnt); else passes++;
        step;
        checks++; if (a_flags !== 7'b0000001) $display("FAIL single_ready_again got %b want %b", a_flags, 7'b0000001); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [6:0] e;
        reset_a;
        a_valid = 1'b1; a_data = 8'hFF;
        step;
        a_data = 8'h00;
        #1;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) step;
            e = {(c == 1), (c >= 2 && c <= 9), (c >= 2 && c <= 9), (c == 2), (c == 9), (c == 10), 1'b0};
            checks++; if (a_flags !== e) $display("FAIL b2b_w1_c%0d got %b want %b", c, a_flags, e); else passes++;
        end
        checks++; if (a_word_cnt !== 16'd1) $display("FAIL b2b_cnt1 got %0d want 1", a_word_cnt); else passes++;
        step;
        checks++; if (a_flags !== 7'b0000001) $display("FAIL b2b_accept2 got %b want %b", a_flags, 7'b0000001); else passes++;
        step;
        a_valid = 1'b0;
        checks++; if (a_flags !== 7'b1000000) $display("FAIL b2b_clr2 got %b want %b", a_flags, 7'b1000000); else passes++;
        for (int i = 0; i < 8; i++) begin
            step;
            e = {1'b0, 1'b1, 1'b0, (i == 0), (i == 7), 1'b0, 1'b0};
            checks++; if (a_flags !== e) $display("FAIL b2b_w2_bit%0d got %b want %b", i, a_flags, e); else passes++;
        end
        step;
        checks++; if (a_flags !== 7'b0000010) $display("FAIL b2b_strobe2 got %b want %b", a_flags, 7'b0000010); else passes++;
        checks++; if (a_word_cnt !== 16'd2) $display("FAIL b2b_cnt2 got %0d want 2", a_word_cnt); else passes++;
        step;
    endtask

    task automatic test_reset_mid;
        reset_a;
        a_valid = 1'b1; a_data = 8'hA5;
        step;
        a_valid = 1'b0;
        repeat (4) step;
        checks++; if (a_flags !== 7'b0100000) $display("FAIL mid_bit4 got %b want %b", a_flags, 7'b0100000); else passes++;
        a_rst = 1'b1;
        step;
        a_rst = 1'b0;
        #1;
        checks++; if (a_flags !== 7'b0000001) $display("FAIL mid_cleared got %b want %b", a_flags, 7'b0000001); else passes++;
        checks++; if (a_word_cnt !== 16'd0) $display("FAIL mid_cnt got %0d want 0", a_word_cnt); else passes++;
        for (int i = 0; i < 8; i++) begin
            step;
            checks++; if (a_flags !== 7'b0000001) $display("FAIL mid_quiet%0d got %b want %b", i, a_flags, 7'b0000001); else passes++;
        end
    endtask

    task automatic test_rst_with_valid;
        a_rst = 1'b1; a_valid = 1'b1; a_data = 8'h33;
        #1;
        checks++; if (a_in_ready !== 1'b0) $display("FAIL rstv_ready got %b want 0", a_in_ready); else passes++;
        step;
        a_rst = 1'b0; a_valid = 1'b0;
        #1;
        checks++; if (a_flags !== 7'b0000001) $display("FAIL rstv_no_clr got %b want %b", a_flags, 7'b0000001); else passes++;
        step;
        checks++; if (a_flags !== 7'b0000001) $display("FAIL rstv_idle got %b want %b", a_flags, 7'b0000001); else passes++;
        checks++; if (a_word_cnt !== 16'd0) $display("FAIL rstv_cnt got %0d want 0", a_word_cnt); else passes++;
    endtask

    task automatic send_div9(input logic [7:0] w, input logic want);
        int n;
        n = 0;
        while (!a_in_ready && n < 20) begin step; n++; end
        a_valid = 1'b1; a_data = w;
        step;
        a_valid = 1'b0;
        n = 0;
        while (!a_res_strobe && n < 20) begin step; n++; end
        checks++;
        if (!a_res_strobe) $display("FAIL div9_timeout word %h got no strobe want strobe", w);
        else if (chk_out !== want) $display("FAIL div9_%h got %b want %b", w, chk_out, want);
        else passes++;
        step;
    endtask

    task automatic test_div9;
        send_div9(8'h12, 1'b1);
        send_div9(8'h13, 1'b0);
    endtask

    task automatic test_gap0;
        logic [7:0] w;
        logic [6:0] e;
        w = 8'h5A;
        b_rst = 1'b1; b_valid = 1'b0; b_data = 8'h00;
        step;
        b_rst = 1'b0;
        b_valid = 1'b1; b_data = w;
        step;
        b_valid = 1'b0;
        checks++; if (b_flags !== 7'b1000000) $display("FAIL gap0_clr got %b want %b", b_flags, 7'b1000000); else passes++;
        for (int i = 0; i < 8; i++) begin
            step;
            e = {1'b0, 1'b1, w[7-i], (i == 0), (i == 7), 1'b0, 1'b0};
            checks++; if (b_flags !== e) $display("FAIL gap0_bit%0d got %b want %b", i, b_flags, e); else passes++;
        end
        step;
        checks++; if (b_flags !== 7'b0000011) $display("FAIL gap0_strobe_ready got %b want %b", b_flags, 7'b0000011); else passes++;
        checks++; if (b_word_cnt !== 16'd1) $display("FAIL gap0_cnt got %0d want 1", b_word_cnt); else passes++;
        b_valid = 1'b1; b_data = 8'h01;
        step;
        b_valid = 1'b0;
        checks++; if (b_flags !== 7'b1000000) $display("FAIL gap0_next_clr got %b want %b", b_flags, 7'b1000000); else passes++;
    endtask

    task automatic test_wrap;
        int n;
        logic [1:0] want;
        c_rst = 1'b1; c_valid = 1'b0; c_data = 4'h0;
        step;
        c_rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            want = 2'(k + 1);
            n = 0;
            while (!c_in_ready && n < 12) begin step; n++; end
            c_valid = 1'b1; c_data = 4'(k + 3);
            step;
            c_valid = 1'b0;
            n = 0;
            while (!c_res_strobe && n < 12) begin step; n++; end
            checks++;
            if (!c_res_strobe) $display("FAIL wrap_timeout%0d got no strobe want strobe", k);
            else if (c_word_cnt !== want) $display("FAIL wrap_cnt%0d got %0d want %0d", k, c_word_cnt, want);
            else passes++;
        end
    endtask

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_data = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_data = '0;
        c_rst = 1'b1; c_valid = 1'b0; c_data = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_reset_mid;
        test_rst_with_valid;
        test_div9;
        test_gap0;
        test_wrap;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
